// File: rtl/edge_history.sv
// edge_history: shift history of the most recent transmitter transitions.
// On every emulated time step it emits one saturated "time since edge" per
// tap for the pwl step-response evaluators, plus a signed per-tap weight
// for the downstream summing stage. All outputs are registered.
module edge_history #(
    parameter int n_taps     = 8,
    parameter int time_width = 32,
    parameter int in_width   = 16,
    parameter int in_sat     = 65535
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             time_valid,
    input  logic [time_width-1:0]            time_now,
    input  logic                             edge_valid,
    input  logic [time_width-1:0]            edge_time,
    input  logic                             edge_value,
    output logic [n_taps*in_width-1:0]       out_in,
    output logic [n_taps*2-1:0]              out_weight,
    output logic                             out_valid,
    output logic [$clog2(n_taps+1)-1:0]      n_edges
);

    localparam int CNT_W = $clog2(n_taps + 1);
    localparam logic [time_width-1:0] SAT_T  = time_width'(in_sat);
    localparam logic [in_width-1:0]   SAT_IN = in_width'(in_sat);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(n_taps);

    // Elapsed time since an edge: edges in the future (negative difference
    // when read as signed) give zero, long-past edges clamp to in_sat.
    function automatic logic [in_width-1:0] sat_delta(input logic [time_width-1:0] d);
        if (d[time_width-1]) begin
            return '0;
        end else if (d >= SAT_T) begin
            return SAT_IN;
        end else begin
            return d[in_width-1:0];
        end
    endfunction

    logic                            last_value_q, last_value_d;
    logic [time_width-1:0]           t_q [n_taps];
    logic [time_width-1:0]           t_d [n_taps];
    logic signed [1:0]               w_q [n_taps];
    logic signed [1:0]               w_d [n_taps];
    logic [n_taps-1:0]               occ_q, occ_d;
    logic [CNT_W-1:0]                n_edges_q, n_edges_d;
    logic [n_taps*in_width-1:0]      out_in_q, out_in_d;
    logic [n_taps*2-1:0]             out_weight_q, out_weight_d;
    logic                            out_valid_q;
    logic                            push;
    logic [time_width-1:0]           diff;

    // Next history state (push on a real transition) and the per-tap outputs,
    // computed from the post-push history so a same-cycle edge is included.
    always_comb begin
        push         = edge_valid && (edge_value != last_value_q);
        last_value_d = last_value_q;
        t_d          = t_q;
        w_d          = w_q;
        occ_d        = occ_q;
        n_edges_d    = n_edges_q;
        out_in_d     = '0;
        out_weight_d = '0;
        diff         = '0;
        if (push) begin
            for (int k = n_taps - 1; k > 0; k--) begin
                t_d[k]   = t_q[k-1];
                w_d[k]   = w_q[k-1];
                occ_d[k] = occ_q[k-1];
            end
            t_d[0]       = edge_time;
            w_d[0]       = edge_value ? 2'sd1 : -2'sd1;
            occ_d[0]     = 1'b1;
            last_value_d = edge_value;
            if (n_edges_q != CNT_MAX) begin
                n_edges_d = n_edges_q + CNT_W'(1);
            end
        end
        for (int k = 0; k < n_taps; k++) begin
            diff = time_now - t_d[k];
            if (occ_d[k]) begin
                out_in_d[k*in_width +: in_width] = sat_delta(diff);
                out_weight_d[2*k +: 2]           = w_d[k];
            end
        end
    end

    // Control state and registered outputs; reset discards the history.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_value_q <= 1'b0;
            occ_q        <= '0;
            n_edges_q    <= '0;
            out_valid_q  <= 1'b0;
            out_in_q     <= '0;
            out_weight_q <= '0;
        end else begin
            last_value_q <= last_value_d;
            occ_q        <= occ_d;
            n_edges_q    <= n_edges_d;
            out_valid_q  <= time_valid;
            if (time_valid) begin
                out_in_q     <= out_in_d;
                out_weight_q <= out_weight_d;
            end
        end
    end

    // Timestamp/weight payload; only meaningful where occ_q is set.
    always_ff @(posedge clk) begin
        t_q <= t_d;
        w_q <= w_d;
    end

    assign out_in     = out_in_q;
    assign out_weight = out_weight_q;
    assign out_valid  = out_valid_q;
    assign n_edges    = n_edges_q;

endmodule

// File: tb/tb_edge_history.sv
// Directed testbench for edge_history with hand-computed expectations.
module tb_edge_history;

    localparam int NT = 8;
    localparam int TW = 32;
    localparam int IW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              time_valid = 1'b0;
    logic [TW-1:0]     time_now = '0;
    logic              edge_valid = 1'b0;
    logic [TW-1:0]     edge_time = '0;
    logic              edge_value = 1'b0;
    logic [NT*IW-1:0]  out_in;
    logic [NT*2-1:0]   out_weight;
    logic              out_valid;
    logic [3:0]        n_edges;

    int n_checks = 0;
    int n_fails  = 0;

    edge_history #(.n_taps(NT), .time_width(TW), .in_width(IW), .in_sat(65535)) dut (
        .clk        (clk),
        .rst        (rst),
        .time_valid (time_valid),
        .time_now   (time_now),
        .edge_valid (edge_valid),
        .edge_time  (edge_time),
        .edge_value (edge_value),
        .out_in     (out_in),
        .out_weight (out_weight),
        .out_valid  (out_valid),
        .n_edges    (n_edges)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] tap_in(input int k);
        return out_in[k*IW +: IW];
    endfunction

    function automatic logic [1:0] tap_w(input int k);
        return out_weight[2*k +: 2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_edge(input logic [TW-1:0] t, input logic v);
        edge_valid = 1'b1;
        edge_time  = t;
        edge_value = v;
        tick();
        edge_valid = 1'b0;
    endtask

    task automatic do_time(input logic [TW-1:0] t);
        time_valid = 1'b1;
        time_now   = t;
        tick();
        time_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_in", 128'(out_in), 128'(0));
        check("rst_w", 128'(out_weight), 128'(0));
        check("rst_nedges", 128'(n_edges), 128'(0));

        // Empty history
        tick();
        check("idle_valid", 128'(out_valid), 128'(0));
        do_time(100);
        check("empty_valid", 128'(out_valid), 128'(1));
        check("empty_in", 128'(out_in), 128'(0));
        check("empty_w", 128'(out_weight), 128'(0));
        check("empty_nedges", 128'(n_edges), 128'(0));
        tick();
        check("valid_one_cycle", 128'(out_valid), 128'(0));

        // Two edges
        do_edge(10, 1'b1);
        check("nedges_after_1", 128'(n_edges), 128'(1));
        do_edge(20, 1'b0);
        do_time(50);
        check("two_tap0_in", 128'(tap_in(0)), 128'(30));
        check("two_tap0_w", 128'(tap_w(0)), 128'(2'b11));
        check("two_tap1_in", 128'(tap_in(1)), 128'(40));
        check("two_tap1_w", 128'(tap_w(1)), 128'(2'b01));
        check("two_rest_w", 128'(out_weight[15:4]), 128'(0));
        check("two_rest_in", 128'(out_in[NT*IW-1:2*IW]), 128'(0));
        check("two_nedges", 128'(n_edges), 128'(2));

        // Repeated level is ignored
        do_reset();
        do_edge(10, 1'b1);
        do_edge(30, 1'b1);
        do_time(50);
        check("rep_tap0_in", 128'(tap_in(0)), 128'(40));
        check("rep_tap0_w", 128'(tap_w(0)), 128'(2'b01));
        check("rep_tap1_w", 128'(tap_w(1)), 128'(0));
        check("rep_nedges", 128'(n_edges), 128'(1));

        // Ten alternating edges overflow the eight taps
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_edge(TW'(i * 10), (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        do_time(100);
        check("ovf_nedges", 128'(n_edges), 128'(8));
        check("ovf_tap0_in", 128'(tap_in(0)), 128'(10));
        check("ovf_tap0_w", 128'(tap_w(0)), 128'(2'b11));
        check("ovf_tap7_in", 128'(tap_in(7)), 128'(80));
        check("ovf_tap7_w", 128'(tap_w(7)), 128'(2'b01));
        check("ovf_tap3_in", 128'(tap_in(3)), 128'(40));

        // Future edge
        do_reset();
        do_edge(70000, 1'b1);
        do_time(5);
        check("future_in", 128'(tap_in(0)), 128'(0));
        check("future_w", 128'(tap_w(0)), 128'(2'b01));

        // Saturation
        do_reset();
        do_edge(0, 1'b1);
        do_time(70000);
        check("sat_in", 128'(tap_in(0)), 128'(65535));
        do_time(65535);
        check("sat_edge_in", 128'(tap_in(0)), 128'(65535));
        do_time(65534);
        check("below_sat_in", 128'(tap_in(0)), 128'(65534));

        // Wrap-around of the time counter
        do_reset();
        do_edge(32'hFFFF_FFF6, 1'b1);
        do_time(5);
        check("wrap_in", 128'(tap_in(0)), 128'(15));

        // Same-cycle edge and time step
        do_reset();
        edge_valid = 1'b1;
        edge_time  = 40;
        edge_value = 1'b1;
        time_valid = 1'b1;
        time_now   = 45;
        tick();
        edge_valid = 1'b0;
        time_valid = 1'b0;
        check("same_valid", 128'(out_valid), 128'(1));
        check("same_tap0_in", 128'(tap_in(0)), 128'(5));
        check("same_tap0_w", 128'(tap_w(0)), 128'(2'b01));
        check("same_nedges", 128'(n_edges), 128'(1));

        // Reset mid-stream beats both strobes
        do_edge(50, 1'b0);
        rst        = 1'b1;
        edge_valid = 1'b1;
        edge_time  = 60;
        edge_value = 1'b1;
        time_valid = 1'b1;
        time_now   = 70;
        tick();
        rst        = 1'b0;
        edge_valid = 1'b0;
        time_valid = 1'b0;
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_in", 128'(out_in), 128'(0));
        check("mid_rst_w", 128'(out_weight), 128'(0));
        check("mid_rst_nedges", 128'(n_edges), 128'(0));
        tick();
        check("post_rst_idle", 128'(out_valid), 128'(0));
        do_time(100);
        check("post_rst_valid", 128'(out_valid), 128'(1));
        check("post_rst_w", 128'(out_weight), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/edge_history.md
# edge_history

Upstream stage for the emulated channel's `pwl` step-response evaluators. It records the most recent `n_taps` transmitter transitions (timestamp and direction) in a shift history. On each emulated time step it emits one registered, saturated "time since edge" per tap, which drives each `pwl` instance's `in` port, plus a signed per-tap step weight for the downstream summing stage.

## Interface
Parameters:
- `n_taps`, 8: depth of the edge history, i.e. the number of `pwl` instances fed.
- `time_width`, 32: width of the emulated-time counter; unsigned, wraps modulo 2^time_width.
- `in_width`, 16: width of each per-tap delta; matches `pwl` `in_width`.
- `in_sat`, 65535: saturation value for deltas; must be ≤ 2^in_width−1.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `time_valid`, input, 1: strobe marking a new emulated time step.
- `time_now`, input, time_width: current emulated time; sampled when `time_valid`=1.
- `edge_valid`, input, 1: strobe marking a new transmitted symbol level.
- `edge_time`, input, time_width: timestamp of that symbol boundary.
- `edge_value`, input, 1: new NRZ level.
- `out_in`, output, n_taps*in_width: flattened per-tap deltas; tap k occupies bits [k*in_width +: in_width]; tap 0 is the newest edge.
- `out_weight`, output, n_taps*2: flattened signed 2-bit weights, tap k at [2k +: 2]. Values: +1 for rising, −1 for falling, 0 for an empty tap.
- `out_valid`, output, 1: `out_in` and `out_weight` are valid this cycle.
- `n_edges`, output, clog2(n_taps+1): number of occupied taps; saturates at `n_taps`.

## Operation
- State:
  - `last_value`: the current line level.
  - Per tap: `t_k` (time_width bits), `w_k` (2 bits), `occ_k` (1 bit).
  - `n_edges`.
- Edge acceptance:
  - If `edge_valid`=1 and `edge_value`≠`last_value`, push a new entry into tap 0: `t_0`=`edge_time`, `w_0`=+1 if `edge_value`=1 else −1, `occ_0`=1.
  - On a push, taps 0..n_taps−2 shift to taps 1..n_taps−1 and the oldest entry is discarded. `last_value` updates to `edge_value`, and `n_edges` increments, saturating at `n_taps`.
  - If `edge_valid`=1 and `edge_value`=`last_value`, the edge is ignored (no transition). History and `n_edges` are unchanged.
- Delta computation, on `time_valid`=1, for each tap k:
  - Compute `d` = `time_now` − `t_k` modulo 2^time_width.
  - If `occ_k`=0: delta=0 and weight=0.
  - Else if d[time_width−1]=1 (edge lies in the future): delta=0 and weight=`w_k`.
  - Else if d ≥ `in_sat`: delta=`in_sat`.
  - Else: delta=d[in_width−1:0].
- All outputs are registered.
- Simultaneous `edge_valid` and `time_valid`: the edge accepted in that cycle is included in that cycle's computation, at tap 0, with the older taps shifted accordingly.
- Reset:
  - `last_value`=0, every `occ_k`=0, `n_edges`=0.
  - `out_valid`=0, `out_in`=0, `out_weight`=0.
  - Reset has priority over both strobes. Asserting reset mid-stream discards the history, and the next `out_valid` occurs only after a new `time_valid`.

## Timing
- Latency is 1 cycle: `time_valid` at cycle N gives `out_valid`=1 at N+1 for exactly one cycle.
- `out_in` and `out_weight` hold their values until the next update; they are meaningful only when `out_valid`=1.
- `n_edges` updates in the cycle after the accepting edge.
- Back-to-back strobes are supported every cycle, with no stalls and no backpressure.
- The downstream `pwl` adds one more cycle of ROM latency. Aligning `out_weight` against the `pwl` output is the summing stage's job.

## Test plan
- Reset, then `time_valid` with `time_now`=100 and no edges -> next cycle `out_valid`=1, all deltas 0, all weights 0, `n_edges`=0.
- Edges (t=10, v=1), (t=20, v=0), then `time_now`=50 -> tap0 delta=30, w=−1; tap1 delta=40, w=+1; taps 2..7 weight 0; `n_edges`=2.
- Repeated `edge_value`=1 at t=30 after a rising edge at t=10 -> ignored; tap0 is still t=10 and `n_edges` is unchanged.
- 10 alternating edges at t=0,10,…,90, then `time_now`=100 -> `n_edges`=8, tap0 delta=10, tap7 delta=80; the edges at t=0 and t=10 are discarded.
- `time_now`=5 with an edge at t=70000 (future) -> delta 0. `time_now`=70000 with an edge at t=0 -> delta 65535 (saturated). Edge at t=2^32−10 with `time_now`=5 -> delta 15 (wrap-around).
- Same-cycle edge (t=40, v=1) and `time_valid` at `time_now`=45 -> tap0 delta=5, w=+1 in the following cycle. Asserting `rst` mid-stream -> all outputs 0 on the next cycle and `n_edges`=0.
